window3x3_gen: RTL
==================

Name: window3x3_gen

Overview:
Streaming 3x3 neighbourhood generator that feeds the combinational median filter. It accepts a raster-order pixel stream and buffers two previous lines. It emits one full 3x3 window per interior pixel, in the same arr[row][col] layout the median block consumes. It sits between the pixel source (frame reader / camera interface) and the median stage; its output drives the median input directly or through a register slice.

Parameters:
IMG_W, 640, pixels per line (>=3); sets line-buffer depth.
IMG_H, 480, lines per frame (>=3).
PIX_W, 8, bits per pixel; must equal the median datapath width.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  pixel available.
in_ready  output  1  block can accept a pixel this cycle.
in_pix  input  PIX_W  pixel value, raster order.
in_sof  input  1  marks first pixel of a frame; qualified by in_valid&&in_ready.
out_valid  output  1  window valid.
out_ready  input  1  downstream accepts window.
out_win  output  PIX_W x 3 x 3  window; [r][c], r=0 top line (y-2), r=2 current line (y); c=0 column x-2, c=2 column x.
out_eof  output  1  qualifies last window of a frame (centre at x=IMG_W-2, y=IMG_H-2).

Behaviour:
- Reset (async assert, sync deassert handled upstream): out_valid=0, out_win all 0, out_eof=0, x=0, y=0, window shift register 0. Line-buffer contents are not reset and are don't-care.
- in_ready = !out_valid || out_ready. It does not depend on in_valid, so there is no comb loop.
- Accept = in_valid && in_ready. On accept, with counters (x,y) taken before update:
  - If in_sof=1, treat the pixel as x=0, y=0 regardless of the counters.
  - Build new column {lb1[x], lb0[x], in_pix}, i.e. lines y-2, y-1, y. Shift it into window column 2; columns 1 and 2 move to 0 and 1.
  - Write lb1[x]<=lb0[x] and lb0[x]<=in_pix in the same cycle (read-before-write).
  - If x>=2 && y>=2: next cycle out_valid=1, out_win=updated window, out_eof=(x==IMG_W-1 && y==IMG_H-1).
  - Counter update: x increments. At x==IMG_W-1, x wraps to 0 and y increments. At y==IMG_H-1 with x==IMG_W-1, both wrap to 0.
- Output handshake: out_valid && out_ready clears out_valid unless a new window is loaded the same cycle. out_win/out_eof hold stable while out_valid && !out_ready.
- Latency: 1 cycle from accepting pixel (x,y) to its window on out_win.
- Windows per frame: (IMG_W-2)*(IMG_H-2). No border windows are emitted; rows 0-1 and columns 0-1 only fill buffers.
- Counter widths: $clog2(IMG_W) and $clog2(IMG_H). No overflow beyond wrap.
- in_sof mid-frame: resync to (0,0). Stale line data is harmless because y<2 suppresses output for two lines. A window already held in the output register is still delivered.
- Reset mid-frame: all state cleared immediately; the next frame must start with in_sof or from counter (0,0).
- in_sof while x,y already (0,0): no special effect.

Optional Feature:
WIN3X3_COORD_EN:
- Defined: adds outputs out_cx [$clog2(IMG_W)-1:0] and out_cy [$clog2(IMG_H)-1:0]. They give the window-centre coordinate (x-1, y-1), registered with out_win, reset 0, and held under backpressure.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package median_pkg: PIX_W localparam default, typedef pixel_t (logic [PIX_W-1:0]), typedef window_t (pixel_t [2:0][2:0]) shared with the median block.
- Sub-module line_buffer: one IMG_W-deep, PIX_W-wide memory with registered write and asynchronous read at one address. Instantiated twice (lb0, lb1).

Test Plan:
- IMG_W=4, IMG_H=4, pixel=y*16+x, continuous valid, out_ready=1 -> exactly 4 windows. First window one cycle after pixel 0x22 is accepted: rows {00,01,02},{10,11,12},{20,21,22}. Last window rows {11,12,13},{21,22,23},{31,32,33} with out_eof=1.
- Same stream with out_ready low for 5 cycles on the 2nd window -> in_ready low for those cycles, out_win frozen at {01,02,03},{11,12,13},{21,22,23}, and no pixel lost; total windows = 4.
- Two back-to-back frames, in_sof on each first pixel -> 8 windows. Second frame's windows use only second-frame data (offset frame-2 pixels by +0x80 to check).
- in_sof asserted at frame-1 pixel 0x13 -> no window until the new y=2,x=2. Then 4 correct windows from the new frame.
- rst_n pulsed low mid-frame while out_valid=1 -> out_valid=0 and out_win=0 immediately; the subsequent full frame yields 4 correct windows.
- Random in_valid/out_ready (50%), IMG_W=8, IMG_H=6 -> 24 windows matching the reference model; median of each equals the software median.

Source files
------------

// File: rtl/median_pkg.sv
// Shared pixel/window types and default geometry for the 3x3 window generator
// and the median stage it feeds.
package median_pkg;

  localparam int PIX_W     = 8;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int WIN_N     = 3;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef pixel_t [2:0][2:0] window_t;

endpackage

// File: rtl/line_buffer.sv
// One line of pixel storage: registered write, asynchronous read at the same
// address, so a read-modify-write in one cycle returns the old contents.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Contents are never reset; stale data is masked by the row counter upstream.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/window3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a column shift
// register, one window per interior pixel. Optional macro: WIN3X3_COORD_EN.
module window3x3_gen
  import median_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = median_pkg::PIX_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PIX_W-1:0]             in_pix,
  input  logic                         in_sof,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2:0][2:0][PIX_W-1:0]   out_win,
  output logic                         out_eof
`ifdef WIN3X3_COORD_EN
  ,
  output logic [$clog2(IMG_W)-1:0]     out_cx,
  output logic [$clog2(IMG_H)-1:0]     out_cy
`endif
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  typedef logic [2:0][2:0][PIX_W-1:0] win_t;

  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  win_t             r_sh;
  win_t             r_win;
  logic             r_out_valid;
  logic             r_eof;

  logic             w_accept;
  logic             w_emit;
  logic [XW-1:0]    w_x;
  logic [YW-1:0]    w_y;
  logic [XW-1:0]    w_x_nxt;
  logic [YW-1:0]    w_y_nxt;
  logic             w_last_x;
  logic             w_last_y;
  logic [PIX_W-1:0] w_lb0;
  logic [PIX_W-1:0] w_lb1;
  win_t             w_sh_next;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // A start-of-frame pixel is placed at (0,0) no matter where the counters are.
  assign w_x      = in_sof ? '0 : r_x;
  assign w_y      = in_sof ? '0 : r_y;
  assign w_last_x = (w_x == XW'(IMG_W - 1));
  assign w_last_y = (w_y == YW'(IMG_H - 1));
  assign w_x_nxt  = w_last_x ? '0 : w_x + XW'(1);
  assign w_y_nxt  = w_last_x ? (w_last_y ? '0 : w_y + YW'(1)) : w_y;
  assign w_emit   = w_accept && (w_x >= XW'(2)) && (w_y >= YW'(2));

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk     (clk),
    .i_we    (w_accept),
    .i_addr  (w_x),
    .i_wdata (in_pix),
    .o_rdata (w_lb0)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk     (clk),
    .i_we    (w_accept),
    .i_addr  (w_x),
    .i_wdata (w_lb0),
    .o_rdata (w_lb1)
  );

  // Shift the window left by one column and insert {y-2, y-1, y} at column 2.
  always_comb begin
    w_sh_next = r_sh;
    for (int r = 0; r < 3; r++) begin
      w_sh_next[r][0] = r_sh[r][1];
      w_sh_next[r][1] = r_sh[r][2];
    end
    w_sh_next[0][2] = w_lb1;
    w_sh_next[1][2] = w_lb0;
    w_sh_next[2][2] = in_pix;
  end

  // Raster position and column shift register advance on every accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x  <= '0;
      r_y  <= '0;
      r_sh <= '0;
    end else if (w_accept) begin
      r_x  <= w_x_nxt;
      r_y  <= w_y_nxt;
      r_sh <= w_sh_next;
    end
  end

  // Output register: load on an interior pixel, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_win       <= '0;
      r_eof       <= 1'b0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_win       <= w_sh_next;
      r_eof       <= w_last_x && w_last_y;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_win   = r_win;
  assign out_eof   = r_eof;

`ifdef WIN3X3_COORD_EN
  logic [XW-1:0] r_cx;
  logic [YW-1:0] r_cy;

  // Window-centre coordinate travels with the window it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (w_emit) begin
      r_cx <= w_x - XW'(1);
      r_cy <= w_y - YW'(1);
    end
  end

  assign out_cx = r_cx;
  assign out_cy = r_cy;
`endif

endmodule
